// File: rtl/pulse_pkg.sv
// Shared types and sizing helpers for the pulse scheduler.
package pulse_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP
    } state_t;

    // Bits needed to count down from the larger of the two interval lengths.
    function automatic int unsigned cnt_width(input int unsigned pw, input int unsigned gap);
        int unsigned m;
        m = (pw > gap) ? pw : gap;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request strictly after the
// last-served index, wrapping around.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] request,
    input  logic [IW-1:0]    last,
    output logic [N_REQ-1:0] winner,
    output logic [IW-1:0]    index,
    output logic             valid
);

    int unsigned pos;

    always_comb begin
        valid = 1'b0;
        index = '0;
        pos   = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            pos = (32'(last) + k) % N_REQ;
            if (!valid && request[pos]) begin
                valid = 1'b1;
                index = IW'(pos);
            end
        end
        winner = valid ? (N_REQ'(1) << index) : '0;
    end

endmodule

// File: rtl/pulse_scheduler.sv
// Shares one pulse generator among N_REQ requesters: rising request edges are
// queued and served round-robin as fixed-width pulses separated by a guard gap.
module pulse_scheduler
    import pulse_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned PULSE_WIDTH = 5,
    parameter int unsigned GAP         = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic             pulse,
    output logic [N_REQ-1:0] grant,
    output logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] pending,
    output logic             busy
);

    localparam int unsigned CW = cnt_width(PULSE_WIDTH, GAP);
    localparam int unsigned IW = $clog2(N_REQ);
    localparam logic [CW-1:0] PW_LOAD  = CW'(PULSE_WIDTH - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'((GAP > 0) ? (GAP - 1) : 0);

    state_t           state, state_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic [N_REQ-1:0] req_prev;
    logic [N_REQ-1:0] rise, cand, served;
    logic [N_REQ-1:0] pending_next, grant_next, done_next;
    logic [N_REQ-1:0] win_onehot;
    logic [IW-1:0]    last, last_next, win_index;
    logic             win_valid, pulse_next, busy_next;

    assign rise = req & ~req_prev;
    assign cand = pending | rise;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr_pick (
        .request (cand),
        .last    (last),
        .winner  (win_onehot),
        .index   (win_index),
        .valid   (win_valid)
    );

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        last_next  = last;
        pulse_next = 1'b0;
        grant_next = '0;
        done_next  = '0;
        served     = '0;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    state_next = PULSE;
                    pulse_next = 1'b1;
                    grant_next = win_onehot;
                    served     = win_onehot;
                    cnt_next   = PW_LOAD;
                    last_next  = win_index;
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    done_next  = grant;
                    state_next = (GAP == 0) ? IDLE : pulse_pkg::GAP;
                    cnt_next   = GAP_LOAD;
                end else begin
                    pulse_next = 1'b1;
                    grant_next = grant;
                    cnt_next   = cnt - CW'(1);
                end
            end
            pulse_pkg::GAP: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        pending_next = cand & ~served;
        busy_next    = (state_next != IDLE);
    end

    // req_prev resets high so a line already asserted at release is not an edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            req_prev <= '1;
            pending  <= '0;
            pulse    <= 1'b0;
            grant    <= '0;
            done     <= '0;
            busy     <= 1'b0;
            last     <= IW'(N_REQ - 1);
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            req_prev <= req;
            pending  <= pending_next;
            pulse    <= pulse_next;
            grant    <= grant_next;
            done     <= done_next;
            busy     <= busy_next;
            last     <= last_next;
        end
    end

endmodule

// File: tb/tb_pulse_scheduler.sv
// Directed self-checking bench for pulse_scheduler with default parameters.
module tb_pulse_scheduler;

    localparam int unsigned PW = 5;

    logic       clock;
    logic       reset;
    logic [3:0] req;
    logic       pulse;
    logic [3:0] grant;
    logic [3:0] done;
    logic [3:0] pending;
    logic       busy;

    int compared = 0;
    int fails    = 0;

    pulse_scheduler #(
        .N_REQ       (4),
        .PULSE_WIDTH (PW),
        .GAP         (2)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .pulse   (pulse),
        .grant   (grant),
        .done    (done),
        .pending (pending),
        .busy    (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    a_len: assert property (@(posedge clock) disable iff (!reset)
                            $rose(pulse) |-> pulse [* PW] ##1 !pulse)
        else begin
            fails++;
            $error("FAIL sva_pulse_len: pulse width differs from %0d", PW);
        end

    a_onehot: assert property (@(posedge clock) disable iff (!reset) $onehot0(grant))
        else begin
            fails++;
            $error("FAIL sva_grant_onehot0: grant=%b", grant);
        end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic checkv(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        compared++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Called on the sample just after a pulse starts; returns on the IDLE sample
    // three low cycles later (the next service can start on the following edge).
    task automatic service(input string tag, input logic [3:0] g, input logic [3:0] p);
        check1({tag, "_pulse_first"}, pulse, 1'b1);
        checkv({tag, "_grant"}, grant, g);
        checkv({tag, "_pending"}, pending, p);
        check1({tag, "_busy"}, busy, 1'b1);
        tick(PW - 1);
        check1({tag, "_pulse_last"}, pulse, 1'b1);
        checkv({tag, "_grant_last"}, grant, g);
        checkv({tag, "_done_early"}, done, 4'b0000);
        tick(1);
        check1({tag, "_pulse_off"}, pulse, 1'b0);
        checkv({tag, "_grant_off"}, grant, 4'b0000);
        checkv({tag, "_done"}, done, g);
        check1({tag, "_gap_busy1"}, busy, 1'b1);
        tick(1);
        checkv({tag, "_done_clear"}, done, 4'b0000);
        check1({tag, "_gap_busy2"}, busy, 1'b1);
        check1({tag, "_gap_low2"}, pulse, 1'b0);
        tick(1);
        check1({tag, "_gap_low3"}, pulse, 1'b0);
        check1({tag, "_idle_busy"}, busy, 1'b0);
    endtask

    task automatic do_reset(input logic [3:0] hold);
        req = hold;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] sim_g [4];
        logic [3:0] sim_p [4];
        sim_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        sim_p = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};

        reset = 1'b0;
        req   = 4'b0000;

        #10;
        check1("rst_pulse", pulse, 1'b0);
        checkv("rst_grant", grant, 4'b0000);
        checkv("rst_done", done, 4'b0000);
        checkv("rst_pending", pending, 4'b0000);
        check1("rst_busy", busy, 1'b0);

        // Single request: release at 22 ns, req[0] rises at 47 ns.
        #12 reset = 1'b1;
        #25;
        check1("single_pre_pulse", pulse, 1'b0);
        check1("single_pre_busy", busy, 1'b0);
        req = 4'b0001;
        tick(1);
        service("single", 4'b0001, 4'b0000);
        req = 4'b0000;

        // Simultaneous rises from a fresh pointer: served 0,1,2,3.
        do_reset(4'b0000);
        checkv("simul_rst_pending", pending, 4'b0000);
        req = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            tick(1);
            service($sformatf("simul%0d", r), sim_g[r], sim_p[r]);
        end
        tick(1);
        check1("simul_after_none", pulse, 1'b0);

        // Fairness: requester 0 re-triggered while 2 is pending -> 0,2,0.
        req = 4'b0000;
        tick(1);
        req = 4'b0101;
        tick(1);
        req = 4'b0100;
        service("fair0", 4'b0001, 4'b0100);
        req = 4'b0101;
        tick(1);
        req = 4'b0100;
        service("fair2", 4'b0100, 4'b0001);
        tick(1);
        service("fair0b", 4'b0001, 4'b0000);

        // Coalescing: three rises of req[1] while it waits behind requester 2.
        req = 4'b0000;
        tick(1);
        req = 4'b0100;
        tick(1);
        checkv("coal_owner", grant, 4'b0100);
        req = 4'b0110;
        tick(1);
        checkv("coal_queued", pending, 4'b0010);
        req = 4'b0100;
        tick(1);
        req = 4'b0110;
        tick(1);
        checkv("coal_second", pending, 4'b0010);
        req = 4'b0100;
        tick(1);
        req = 4'b0110;
        tick(1);
        req = 4'b0100;
        tick(1);
        checkv("coal_third", pending, 4'b0010);
        check1("coal_gap_low", pulse, 1'b0);
        tick(1);
        check1("coal_idle_low", pulse, 1'b0);
        tick(1);
        check1("coal_serve_pulse", pulse, 1'b1);
        checkv("coal_serve_grant", grant, 4'b0010);
        checkv("coal_serve_pending", pending, 4'b0000);
        req = 4'b0110;
        tick(1);
        checkv("coal_requeue", pending, 4'b0010);
        check1("coal_requeue_pulse", pulse, 1'b1);
        req = 4'b0100;
        tick(6);
        check1("coal_requeue_idle", busy, 1'b0);
        tick(1);
        service("coal_again", 4'b0010, 4'b0000);
        tick(1);
        check1("coal_no_extra", pulse, 1'b0);
        checkv("coal_no_pending", pending, 4'b0000);

        // Held-high req[3] across reset release is not an edge.
        do_reset(4'b1000);
        tick(3);
        check1("held_no_pulse", pulse, 1'b0);
        checkv("held_no_pending", pending, 4'b0000);
        check1("held_no_busy", busy, 1'b0);
        req = 4'b0000;
        tick(1);
        req = 4'b1000;
        tick(1);
        service("held", 4'b1000, 4'b0000);

        // Reset mid-pulse with 1 and 2 queued.
        req = 4'b0000;
        tick(1);
        req = 4'b0111;
        tick(1);
        checkv("midrst_grant", grant, 4'b0001);
        checkv("midrst_pending", pending, 4'b0110);
        tick(2);
        check1("midrst_cycle3", pulse, 1'b1);
        #2 reset = 1'b0;
        #1;
        check1("midrst_pulse", pulse, 1'b0);
        checkv("midrst_grant0", grant, 4'b0000);
        checkv("midrst_pending0", pending, 4'b0000);
        check1("midrst_busy0", busy, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        tick(3);
        check1("post_rst_pulse", pulse, 1'b0);
        checkv("post_rst_pending", pending, 4'b0000);
        check1("post_rst_busy", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, fails);
        $finish;
    end

endmodule

// File: doc/pulse_scheduler.md
Name: pulse_scheduler

Overview:
Shares one pulse generator among N_REQ requesters. A rising edge on any requester's request line queues that requester. A round-robin scheduler then serves queued requesters one at a time. Each service is a PULSE_WIDTH-cycle high pulse on the shared output, followed by a GAP-cycle low guard interval. The block sits between the requester logic and the single physical pulse line, and replaces per-requester edge-to-pulse FSMs.

Parameters:
N_REQ, 4, number of requesters (>=2)
PULSE_WIDTH, 5, clock cycles pulse is held high per service (>=1)
GAP, 2, minimum low cycles between consecutive pulses (>=0)

Ports:
clock  input  1  single clock, all state on posedge
reset  input  1  asynchronous, active-low; 0 clears all state immediately
req  input  N_REQ  per-requester request level; only rising edges count
pulse  output  1  shared pulse, registered
grant  output  N_REQ  one-hot owner of current pulse; all-zero otherwise, registered
done  output  N_REQ  one-cycle strobe to the served requester at end of its pulse, registered
pending  output  N_REQ  queued-but-unserved requests, registered
busy  output  1  high in PULSE or GAP state

Behaviour:
- Reset (reset=0, async): state=IDLE, pulse=0, grant=0, done=0, pending=0, busy=0, counter=0.
  - req_prev resets to all-ones, so a line already high at reset release is not an edge.
  - Round-robin pointer resets so requester 0 has the highest priority first.
- Edge detect, per bit: rise[i] = req[i] & ~req_prev[i], sampled at posedge. Edges are only detected while reset=1.
- Pending update: pending_next = (pending | rise) & ~served, where served is the one-hot chosen at a PULSE entry.
  - A rise on a bit that is already pending is coalesced and never double-queued.
  - A rise on the currently granted requester during PULSE or GAP re-queues it.
- FSM states, in a shared enum:
  - IDLE: if (pending|rise) is nonzero, pick the winner via round-robin. The winner is the first set bit strictly after the last-served index, wrapping modulo N_REQ. On the same posedge set state=PULSE, pulse=1, grant=onehot(winner), clear pending[winner], counter=PULSE_WIDTH-1, and update the pointer to the winner.
  - PULSE: hold pulse and grant. Decrement counter each posedge. When counter==0:
    - pulse=0, grant=0, done=onehot(winner) for exactly one cycle.
    - Go to GAP with counter=GAP-1. If GAP==0, go directly to IDLE.
  - GAP: pulse=0. Decrement counter. When counter==0, go to IDLE.
- Latency: a req bit rises, is sampled high at posedge k, and the FSM is in IDLE. Then pulse is sampled high at posedges k+1..k+PULSE_WIDTH and low at k+PULSE_WIDTH+1.
- Back-to-back service: the next pulse can start at the posedge where GAP expires plus one IDLE evaluation. The low interval between pulses is exactly GAP+1 cycles when GAP>=1, and 1 cycle when GAP==0. This guarantees pulses never merge.
- Simultaneous rises in IDLE: one winner per round-robin. All others stay pending and are served in rotating order.
- A req falling during PULSE does not abort or shorten the pulse.
- Reset asserted mid-PULSE: pulse drops asynchronously, and all queued requests are lost.
- Counter width: $clog2(max(PULSE_WIDTH,GAP)+1).

Decomposition:
- pulse_pkg: typedef enum state_t {IDLE, PULSE, GAP}, plus the helper function for counter width.
- Sub-module rr_pick: combinational round-robin selector. Inputs: request vector and last-served index. Outputs: one-hot winner, winner index, valid.
- The top level holds the edge detect, pending register, FSM and counter.

Test Plan:
- Single request: reset released at 22 ns, req[0] rises at 47 ns → pulse high for exactly 5 cycles, grant=0001 throughout. done[0] strobes for one cycle as pulse falls, then busy stays high for 2 GAP cycles.
- Simultaneous: req=1111 rises in one cycle → four pulses of 5 cycles in order 0,1,2,3. Each is separated by 3 low cycles (GAP=2), grant matches each, and pending counts down 1110, 1100, 1000, 0000.
- Fairness: requester 0 is re-triggered after every service while requester 2 is pending → the served order alternates 0,2,0. Requester 0 never gets two consecutive pulses while 2 is pending.
- Coalescing: req[1] toggles three times while pending[1]=1 before service → exactly one pulse for requester 1. A toggle during its own PULSE → one further pulse after GAP.
- Held-high: req[3] held at 1 through reset release → no pulse. A fall then rise → one pulse.
- Reset mid-pulse: reset=0 on cycle 3 of a pulse with pending=0110 → pulse, grant, pending and busy go to 0 immediately with no clock edge. After release, no pulse occurs without new edges.
- A concurrent assertion runs for all scenarios: pulse rise |-> pulse[*PULSE_WIDTH] ##1 ~pulse, and grant is onehot0.
